// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte requesters, with a tx_done watchdog.
// Define UART_ARB_LOCK_EN to add req_lock, which lets the current owner keep the grant for consecutive bytes.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]          req_lock,
`endif
   output logic [NUM_REQ-1:0]          ack,
   output logic [NUM_REQ-1:0]          done,
   output logic [NUM_REQ-1:0]          grant,
   output logic                        tx_start,
   output logic [DATA_W-1:0]           tx_din,
   input  logic                        tx_busy,
   input  logic                        tx_done,
   output logic                        err_timeout
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]         state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   owner;
   logic [WD_W-1:0]    wd;
   logic [NUM_REQ-1:0] cand;
   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   scan_idx;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

`ifdef UART_ARB_LOCK_EN
   logic lock_q;

   // While locked, only the previous owner may win; the lock lapses once it stops requesting.
   assign cand = (lock_q && req[ptr]) ? onehot(ptr) : req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_q <= 1'b0;
      end else if (state == S_IDLE && lock_q && !req[ptr]) begin
         lock_q <= 1'b0;
      end else if (state == S_WAIT) begin
         if (tx_done)
            lock_q <= req_lock[owner];
         else if (wd == WD_LAST)
            lock_q <= 1'b0;
      end
   end
`else
   assign cand = req;
`endif

   // Scan from ptr+NUM_REQ down to ptr+1 so the nearest requester after ptr is kept last.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      scan_idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         scan_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (cand[scan_idx]) begin
            pick_vld = 1'b1;
            pick_idx = scan_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         ptr         <= IDX_W'(NUM_REQ - 1);
         owner       <= '0;
         wd          <= '0;
         ack         <= '0;
         done        <= '0;
         grant       <= '0;
         tx_start    <= 1'b0;
         tx_din      <= '0;
         err_timeout <= 1'b0;
      end else begin
         ack         <= '0;
         done        <= '0;
         tx_start    <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_vld && !tx_busy) begin
                  owner  <= pick_idx;
                  grant  <= onehot(pick_idx);
                  tx_din <= req_data[pick_idx*DATA_W +: DATA_W];
                  state  <= S_START;
               end
            end
            S_START: begin
               tx_start <= 1'b1;
               ack      <= onehot(owner);
               ptr      <= owner;
               wd       <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               // tx_done takes priority over an expiring watchdog in the same cycle.
               if (tx_done) begin
                  done  <= onehot(owner);
                  grant <= '0;
                  state <= S_IDLE;
               end else if (wd == WD_LAST) begin
                  err_timeout <= 1'b1;
                  grant       <= '0;
                  state       <= S_IDLE;
               end else if (wd != '1) begin
                  wd <= wd + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single transfer, fairness, busy gating, watchdog and lock/no-lock ordering.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int TO = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic [NR-1:0] req;
   logic [NR*DW-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
   logic [NR-1:0] req_lock;
`endif
   logic [NR-1:0] ack;
   logic [NR-1:0] done;
   logic [NR-1:0] grant;
   logic          tx_start;
   logic [DW-1:0] tx_din;
   logic          tx_busy;
   logic          tx_done;
   logic          err_timeout;

   int n_tests = 0;
   int n_fail  = 0;
   logic ok;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .req_data(req_data),
`ifdef UART_ARB_LOCK_EN
      .req_lock(req_lock),
`endif
      .ack(ack),
      .done(done),
      .grant(grant),
      .tx_start(tx_start),
      .tx_din(tx_din),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .err_timeout(err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One full transfer starting in IDLE with req already driven; tx_done is returned one cycle into WAIT_DONE.
   task automatic xfer(input logic [NR-1:0] g, input logic [DW-1:0] d, input string tag);
      tick;
      chk({tag, "_grant"}, 32'(grant), 32'(g));
      chk({tag, "_din"}, 32'(tx_din), 32'(d));
      tick;
      chk({tag, "_start"}, 32'(tx_start), 32'h1);
      chk({tag, "_ack"}, 32'(ack), 32'(g));
      tick;
      chk({tag, "_pulse_end"}, 32'({ack, tx_start}), 32'h0);
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'(g));
      chk({tag, "_grant_clr"}, 32'(grant), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst      = 1'b0;
      req      = '0;
      req_data = '0;
      tx_busy  = 1'b0;
      tx_done  = 1'b0;
`ifdef UART_ARB_LOCK_EN
      req_lock = '0;
`endif
      tick;
      tick;
      chk("reset_state", 32'({grant, ack, done, tx_start, err_timeout, tx_din}), 32'h0);
      rst = 1'b1;
      tick;

      // single requester 2, tx_done 100 cycles after tx_start
      req      = 4'b0100;
      req_data = 32'h33A5_1100;
      tick;
      chk("t2_grant", 32'(grant), 32'h4);
      chk("t2_din", 32'(tx_din), 32'hA5);
      chk("t2_no_start_yet", 32'(tx_start), 32'h0);
      tick;
      chk("t2_start", 32'(tx_start), 32'h1);
      chk("t2_ack", 32'(ack), 32'h4);
      req      = 4'b0000;
      req_data = 32'hFFFF_FFFF;
      ok = 1'b1;
      for (int i = 1; i < 100; i++) begin
         tick;
         if (done != 0 || err_timeout || tx_start || ack != 0) ok = 1'b0;
      end
      chk("t2_quiet_wait", 32'(ok), 32'h1);
      chk("t2_din_held", 32'(tx_din), 32'hA5);
      chk("t2_grant_held", 32'(grant), 32'h4);
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      chk("t2_done", 32'(done), 32'h4);
      chk("t2_grant_clr", 32'(grant), 32'h0);
      tick;
      chk("t2_done_1cyc", 32'(done), 32'h0);

      // asynchronous reset in the middle of a transfer
      req      = 4'b0100;
      req_data = 32'h33A5_1100;
      tick;
      tick;
      chk("t1_pre_start", 32'(tx_start), 32'h1);
      rst = 1'b0;
      #1;
      chk("t1_async_clear", 32'({grant, ack, done, tx_start, err_timeout, tx_din}), 32'h0);
      req = 4'b0000;
      tick;
      rst = 1'b1;

      // fairness: all four requesting, ptr restarts at NUM_REQ-1
      req      = 4'b1111;
      req_data = 32'h1312_1110;
      xfer(4'b0001, 8'h10, "t3_0");
      xfer(4'b0010, 8'h11, "t3_1");
      xfer(4'b0100, 8'h12, "t3_2");
      xfer(4'b1000, 8'h13, "t3_3");
      xfer(4'b0001, 8'h10, "t3_4");
      xfer(4'b0010, 8'h11, "t3_5");
      req = 4'b0000;

      // tx_done while idle is ignored
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      chk("idle_txdone_ignored", 32'({done, grant}), 32'h0);

      // request dropped before it could be arbitrated
      tx_busy = 1'b1;
      req     = 4'b0001;
      tick;
      tick;
      req     = 4'b0000;
      tx_busy = 1'b0;
      tick;
      tick;
      chk("dropped_req", 32'({grant, ack, tx_start}), 32'h0);

      // busy gate
      tx_busy  = 1'b1;
      req      = 4'b0010;
      req_data = 32'h4433_2211;
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (grant != 0 || tx_start) ok = 1'b0;
      end
      chk("t4_busy_blocks", 32'(ok), 32'h1);
      tx_busy = 1'b0;
      xfer(4'b0010, 8'h22, "t4");
      req = 4'b0000;

      // watchdog abort, then tx_done exactly on the last watchdog cycle
      req = 4'b0011;
      tick;
      chk("t5_grant", 32'(grant), 32'h1);
      chk("t5_din", 32'(tx_din), 32'h11);
      tick;
      chk("t5_start", 32'(tx_start), 32'h1);
      req = 4'b0010;
      ok = 1'b1;
      for (int k = 1; k < TO; k++) begin
         tick;
         if (err_timeout || done != 0) ok = 1'b0;
      end
      chk("t5_no_early_abort", 32'(ok), 32'h1);
      chk("t5_grant_held", 32'(grant), 32'h1);
      tick;
      chk("t5_err_timeout", 32'(err_timeout), 32'h1);
      chk("t5_no_done", 32'(done), 32'h0);
      chk("t5_grant_clr", 32'(grant), 32'h0);
      tick;
      chk("t5_err_1cyc", 32'(err_timeout), 32'h0);
      chk("t5_next_grant", 32'(grant), 32'h2);
      tick;
      chk("t5b_start", 32'(tx_start), 32'h1);
      chk("t5b_ack", 32'(ack), 32'h2);
      for (int k = 1; k < TO; k++) tick;
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      chk("t5b_done_wins", 32'(done), 32'h2);
      chk("t5b_no_err", 32'(err_timeout), 32'h0);
      req = 4'b0000;

      // lock ordering with requesters 0 and 1 both pending
      req      = 4'b0011;
      req_data = 32'h0000_BBAA;
`ifdef UART_ARB_LOCK_EN
      req_lock = 4'b0001;
      xfer(4'b0001, 8'hAA, "t6_a");
      xfer(4'b0001, 8'hAA, "t6_b");
      req_lock = 4'b0000;
      xfer(4'b0001, 8'hAA, "t6_c");
      xfer(4'b0010, 8'hBB, "t6_d");
`else
      xfer(4'b0001, 8'hAA, "t6_a");
      xfer(4'b0010, 8'hBB, "t6_b");
      xfer(4'b0001, 8'hAA, "t6_c");
      xfer(4'b0010, 8'hBB, "t6_d");
`endif
      req = 4'b0000;
      tick;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
